// File: rtl/tqvp_hx2003_pulse_pkg.sv
// Shared types and constants for the pulse job scheduler.
// Covers the FSM state encoding, the field widths and the packed job record.
package tqvp_hx2003_pulse_pkg;

    localparam int IDX_W     = 7;
    localparam int CNT_W     = 8;
    localparam int GAP_MAX_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_GAP  = 3'd4
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0]     end_index;
        logic [IDX_W-1:0]     loopback_index;
        logic [CNT_W-1:0]     loop_count;
        logic [GAP_MAX_W-1:0] gap;
    } job_t;

    localparam int JOB_W       = $bits(job_t);
    localparam int JOB_NOGAP_W = JOB_W - GAP_MAX_W;

endpackage

// File: rtl/tqvp_hx2003_pulse_job_fifo.sv
// Synchronous DEPTH-entry job FIFO with an occupancy count and a flush.
// Flush takes priority over push and pop in the same cycle.
module tqvp_hx2003_pulse_job_fifo
    import tqvp_hx2003_pulse_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = JOB_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full  = (count_q == LVL_W'(DEPTH));
    assign empty = (count_q == {LVL_W{1'b0}});
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {LVL_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are qualified by the count, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tqvp_hx2003_pulse_job_scheduler.sv
// Pulse job scheduler: queues transmit jobs and runs them one at a time
// on the pulse transmitter, raising done_pulse / irq on completion.
// Optional feature macro: PULSE_SCHED_GAP_EN (inter-job gap state and storage).
module tqvp_hx2003_pulse_job_scheduler
    import tqvp_hx2003_pulse_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [6:0]             job_end_index,
    input  logic [6:0]             job_loopback_index,
    input  logic [7:0]             job_loop_count,
    input  logic [GAP_W-1:0]       job_gap,
    input  logic                   abort,
    input  logic                   irq_clear,
    output logic                   tx_start,
    output logic [6:0]             tx_end_index,
    output logic [6:0]             tx_loopback_index,
    output logic [7:0]             tx_loop_count,
    input  logic                   tx_active,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   done_pulse,
    output logic                   irq
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef PULSE_SCHED_GAP_EN
    localparam int FIFO_W = JOB_W;
`else
    localparam int FIFO_W = JOB_NOGAP_W;
`endif

    state_e            state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [IDX_W-1:0]  tx_end_q, tx_end_d;
    logic [IDX_W-1:0]  tx_lb_q, tx_lb_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic              done_q, done_d;
    logic              irq_q, irq_d;
    logic              busy_q, busy_d;
    logic              push_s, pop_s, full_s, empty_s, ready_s;
    logic [LVL_W-1:0]  level_s;
    logic [FIFO_W-1:0] wdata_s, rdata_s;
    job_t              head_s;
`ifdef PULSE_SCHED_GAP_EN
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
`else
    logic              unused_gap_s;
`endif

    assign ready_s = rst_n && !full_s && !abort;
    assign push_s  = job_valid && ready_s;

`ifdef PULSE_SCHED_GAP_EN
    assign wdata_s = {job_end_index, job_loopback_index, job_loop_count, GAP_MAX_W'(job_gap)};
    assign head_s  = rdata_s;
`else
    assign wdata_s      = {job_end_index, job_loopback_index, job_loop_count};
    assign head_s       = {rdata_s, {GAP_MAX_W{1'b0}}};
    assign unused_gap_s = ^{job_gap, head_s.gap};
`endif

    tqvp_hx2003_pulse_job_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort),
        .push  (push_s),
        .wdata (wdata_s),
        .pop   (pop_s),
        .rdata (rdata_s),
        .count (level_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Sequencing FSM: next state, transmitter controls and completion events.
    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_end_d   = tx_end_q;
        tx_lb_d    = tx_lb_q;
        tx_cnt_d   = tx_cnt_q;
        done_d     = 1'b0;
        pop_s      = 1'b0;
`ifdef PULSE_SCHED_GAP_EN
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
`endif
        if (abort) begin
            state_d    = ST_IDLE;
            tx_start_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Emptiness is registered, so a fresh push is popped one edge later.
                    if (!empty_s) begin
                        pop_s    = 1'b1;
                        state_d  = ST_LOAD;
                        tx_end_d = head_s.end_index;
                        tx_lb_d  = head_s.loopback_index;
                        tx_cnt_d = head_s.loop_count;
`ifdef PULSE_SCHED_GAP_EN
                        gap_d    = GAP_W'(head_s.gap);
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    tx_start_d = 1'b1;
                    state_d    = ST_ARM;
                end
                ST_ARM: begin
                    if (tx_active) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
                ST_RUN: begin
                    if (!tx_active) begin
                        tx_start_d = 1'b0;
                        done_d     = 1'b1;
`ifdef PULSE_SCHED_GAP_EN
                        if (gap_q != {GAP_W{1'b0}}) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_GAP: begin
`ifdef PULSE_SCHED_GAP_EN
                    if (gap_cnt_q == GAP_W'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                default: begin
                    state_d    = ST_IDLE;
                    tx_start_d = 1'b0;
                end
            endcase
        end
    end

    // Sticky interrupt: a completion that leaves nothing queued beats a clear.
    always_comb begin
        irq_d = irq_q;
        if (irq_clear) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
        if (done_d && (level_s == {LVL_W{1'b0}}) && !push_s) begin
            irq_d = 1'b1;
        end else begin
            irq_d = irq_d;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_end_q   <= {IDX_W{1'b0}};
            tx_lb_q    <= {IDX_W{1'b0}};
            tx_cnt_q   <= {CNT_W{1'b0}};
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PULSE_SCHED_GAP_EN
            gap_q      <= {GAP_W{1'b0}};
            gap_cnt_q  <= {GAP_W{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_end_q   <= tx_end_d;
            tx_lb_q    <= tx_lb_d;
            tx_cnt_q   <= tx_cnt_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
`ifdef PULSE_SCHED_GAP_EN
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    assign job_ready         = ready_s;
    assign tx_start          = tx_start_q;
    assign tx_end_index      = tx_end_q;
    assign tx_loopback_index = tx_lb_q;
    assign tx_loop_count     = tx_cnt_q;
    assign level             = level_s;
    assign busy              = busy_q;
    assign done_pulse        = done_q;
    assign irq               = irq_q;

endmodule

// File: doc/tqvp_hx2003_pulse_job_scheduler.md
# tqvp_hx2003_pulse_job_scheduler

Queues transmit jobs for the pulse transmitter and sequences them onto it one at a time. Each job carries program end index, loopback index, loop count and an inter-job gap. The scheduler drives the transmitter's start level and program-config fields, detects completion from its valid-output signal and raises a completion interrupt. It sits between the TinyQV register interface and the transmitter core.

## Interface
- DEPTH, 4: job queue entries; power of two, ≥2
- GAP_W, 16: width of inter-job gap counter
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- job_valid  in  1  push request
- job_ready  out  1  queue can accept; = !full && !abort
- job_end_index  in  7  program end index
- job_loopback_index  in  7  loopback index
- job_loop_count  in  8  loop count
- job_gap  in  GAP_W  idle cycles after job completes
- abort  in  1  flush queue, stop transmitter
- irq_clear  in  1  clears irq
- tx_start  out  1  transmitter start level; transmitter starts on its rising edge, resets while low
- tx_end_index  out  7  registered, stable while tx_start=1
- tx_loopback_index  out  7  registered
- tx_loop_count  out  8  registered
- tx_active  in  1  transmitter valid-output
- level  out  $clog2(DEPTH)+1  queued job count (excludes running job)
- busy  out  1  state ≠ IDLE
- done_pulse  out  1  one cycle per completed job
- irq  out  1  sticky: last job done with queue empty

## Operation
- Push: job_valid && job_ready at an edge writes all four fields to tail; level+1.
- FSM states IDLE, LOAD, ARM, RUN, GAP:
  - IDLE: level>0 → LOAD; pop head into tx_* regs and latched gap at this edge.
  - LOAD: one cycle, tx_start=0 → ARM; tx_start←1.
  - ARM: wait for tx_active=1 → RUN. No timeout.
  - RUN: on tx_active=0: tx_start←0, done_pulse←1; → GAP if latched gap>0, else IDLE.
  - GAP: counter loaded with gap, decrements each cycle; at 1 → IDLE.
- Loop-forever jobs never complete; only abort ends them.
- irq set on done_pulse when level=0 and no push that same cycle; cleared by irq_clear; set wins over simultaneous clear.
- abort (any state): next edge → IDLE, tx_start=0, queue emptied, level=0, no done_pulse, irq unchanged. Pushes during abort are dropped (job_ready=0).
- Push while full: refused (job_ready=0), even if a pop occurs the same cycle.
- Push into empty queue in IDLE: popped at the following edge, never the same edge.

## Timing
- Reset: tx_start, tx_* fields, level, busy, done_pulse, irq = 0; job_ready=0 during reset, 1 afterwards; state IDLE; queue empty.
- Accept at edge E0; IDLE→LOAD and tx_* valid after E1; tx_start high after E2.
- tx_start low for ≥2 cycles between jobs (IDLE+LOAD) with gap=0; gap+2 cycles otherwise. Guarantees the transmitter's edge detector re-fires.
- done_pulse is asserted the cycle after the edge where RUN samples tx_active=0.
- level updates on the edge after push/pop; simultaneous push+pop leaves level unchanged.

## Configuration
- PULSE_SCHED_GAP_EN defined: GAP state, gap counter and job_gap storage are present, as described above.
- Not defined: job_gap is ignored and not stored; RUN always → IDLE; minimum 2-cycle low on tx_start.

## Structure
- Package tqvp_hx2003_pulse_pkg holds:
  - FSM state enum
  - index width (7) and loop-count width (8) constants
  - packed job struct {end_index, loopback_index, loop_count, gap}
- Sub-module tqvp_hx2003_pulse_job_fifo: synchronous DEPTH-entry FIFO with count, full and empty flags, and flush.

## Test plan
- Reset then push one job (end 5, loop 2, gap 0) → tx_start rises after E2. Bench drives tx_active 1 then 0 → single done_pulse, irq=1, busy=0.
- Push 4 jobs with DEPTH=4 → 5th push sees job_ready=0. After first pop level=3 and job_ready=1.
- Two jobs, first gap=10 → tx_start low exactly 12 cycles between jobs; second job's tx_* fields match its push values.
- Abort during RUN with 2 queued → tx_start=0 next cycle, level=0, no done_pulse, state IDLE.
- irq set and irq_clear in the same cycle → irq=1. irq_clear alone → irq=0.
- Macro undefined, job gap=50 → tx_start low 2 cycles between jobs.
